// File: rtl/sw_seq_loader.sv
// Serial base loader for the Smith-Waterman aligner: packs one reference
// and one query frame from a 2-bit base stream and holds them for the core.
module sw_seq_loader #(
    parameter int REF_LEN    = 15,
    parameter int QUERY_LEN  = 10,
    parameter int BASE_WIDTH = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [BASE_WIDTH-1:0]           in_base,
    input  logic                            in_last,
    output logic [REF_LEN*BASE_WIDTH-1:0]   ref_seq,
    output logic [QUERY_LEN*BASE_WIDTH-1:0] query_seq,
    output logic                            seq_valid,
    input  logic                            seq_ack,
    output logic                            err_len,
    output logic [7:0]                      frame_count
);

    localparam logic [7:0] REF_LAST = 8'(REF_LEN - 1);
    localparam logic [7:0] QRY_LAST = 8'(QUERY_LEN - 1);

    typedef enum logic [1:0] {
        S_LOAD_REF,
        S_LOAD_QRY,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t                          r_state;
    logic [7:0]                      r_ref_cnt;
    logic [7:0]                      r_qry_cnt;
    logic [REF_LEN*BASE_WIDTH-1:0]   r_ref_seq;
    logic [QUERY_LEN*BASE_WIDTH-1:0] r_qry_seq;
    logic                            r_seq_valid;
    logic                            r_err_len;
    logic [7:0]                      r_frame_count;

    logic w_xfer;
    logic w_in_ref;
    logic w_in_qry;
    logic w_qry_end;
    logic w_short;
    logic w_long;
    logic w_err;

    assign in_ready  = (r_state != S_HOLD);
    assign w_xfer    = in_valid & in_ready;
    assign w_in_ref  = (r_state == S_LOAD_REF);
    assign w_in_qry  = (r_state == S_LOAD_QRY);
    assign w_qry_end = (r_qry_cnt == QRY_LAST);

    // Short: frame ended early. Long: last query base arrived without in_last.
    assign w_short = w_xfer & in_last &
                     (w_in_ref | (w_in_qry & ~w_qry_end));
    assign w_long  = w_xfer & ~in_last & w_in_qry & w_qry_end;
    assign w_err   = w_short | w_long;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_LOAD_REF;
            r_ref_cnt     <= '0;
            r_qry_cnt     <= '0;
            r_ref_seq     <= '0;
            r_qry_seq     <= '0;
            r_seq_valid   <= 1'b0;
            r_err_len     <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_err_len <= 1'b0;
            unique case (r_state)
                S_LOAD_REF: begin
                    if (w_xfer) begin
                        for (int k = 0; k < REF_LEN; k++) begin
                            if (r_ref_cnt == 8'(k)) begin
                                r_ref_seq[(REF_LEN-1-k)*BASE_WIDTH +: BASE_WIDTH]
                                    <= in_base;
                            end
                        end
                        if (r_ref_cnt == REF_LAST) begin
                            r_ref_cnt <= '0;
                            r_state   <= S_LOAD_QRY;
                        end else begin
                            r_ref_cnt <= r_ref_cnt + 8'd1;
                        end
                    end
                end
                S_LOAD_QRY: begin
                    if (w_xfer) begin
                        for (int k = 0; k < QUERY_LEN; k++) begin
                            if (r_qry_cnt == 8'(k)) begin
                                r_qry_seq[(QUERY_LEN-1-k)*BASE_WIDTH +: BASE_WIDTH]
                                    <= in_base;
                            end
                        end
                        if (w_qry_end) begin
                            r_qry_cnt <= '0;
                            if (in_last) begin
                                r_state       <= S_HOLD;
                                r_seq_valid   <= 1'b1;
                                r_frame_count <= r_frame_count + 8'd1;
                            end
                        end else begin
                            r_qry_cnt <= r_qry_cnt + 8'd1;
                        end
                    end
                end
                S_HOLD: begin
                    if (seq_ack) begin
                        r_seq_valid <= 1'b0;
                        r_ref_cnt   <= '0;
                        r_qry_cnt   <= '0;
                        r_state     <= S_LOAD_REF;
                    end
                end
                S_DRAIN: begin
                    if (w_xfer && in_last) begin
                        r_state <= S_LOAD_REF;
                    end
                end
                default: r_state <= S_LOAD_REF;
            endcase

            // Errors override whatever the state logic wrote this cycle.
            if (w_err) begin
                r_err_len <= 1'b1;
                r_ref_cnt <= '0;
                r_qry_cnt <= '0;
                r_ref_seq <= '0;
                r_qry_seq <= '0;
                r_state   <= w_long ? S_DRAIN : S_LOAD_REF;
            end
        end
    end

    assign ref_seq     = r_ref_seq;
    assign query_seq   = r_qry_seq;
    assign seq_valid   = r_seq_valid;
    assign err_len     = r_err_len;
    assign frame_count = r_frame_count;

endmodule
